// File: rtl/vga_buf_writer_if.sv
// Pixel-request, clear-command, status and RAM port B bundle for vga_buf_writer.
// master = rasteriser/RAM side, slave = the write engine.
interface vga_buf_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_x;
  logic [4:0]  req_y;
  logic [7:0]  req_pixel;
  logic        clr_start;
  logic        clr_buf;
  logic [7:0]  clr_color;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] ADDR_B;
  logic [15:0] DIN_B;
  logic        WE_B;
  logic [15:0] DOUT_B;

  modport slave (
    input  req_valid, req_x, req_y, req_pixel, clr_start, clr_buf, clr_color, DOUT_B,
    output req_ready, busy, done, err, ADDR_B, DIN_B, WE_B
  );
  modport master (
    output req_valid, req_x, req_y, req_pixel, clr_start, clr_buf, clr_color, DOUT_B,
    input  req_ready, busy, done, err, ADDR_B, DIN_B, WE_B
  );
endinterface

// File: rtl/vga_buf_writer.sv
// Read-modify-write pixel engine for the 16-bit video RAM port B.
// Define VGA_WR_CLEAR_EN to build in the whole-buffer clear engine.
module vga_buf_writer #(
  parameter logic [15:0] BUF1_START = 16'd0,
  parameter logic [15:0] BUF2_START = 16'd5120,
  parameter int          BUF_WORDS  = 5120
) (
  input logic              CLK33MHz,
  input logic              RST,
  vga_buf_writer_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE,
    RD,
    MRG,
    WR
`ifdef VGA_WR_CLEAR_EN
    , CLR
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic        lane_q, lane_d;
  logic [7:0]  pix_q, pix_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ready;

  logic [13:0] req_lin;
  logic [15:0] req_word;
  assign req_lin  = 14'(bus.req_y[3:0]) * 14'd640 + {4'b0, bus.req_x};
  assign req_word = (bus.req_y[4] ? BUF2_START : BUF1_START) + {3'b0, req_lin[13:1]};

`ifdef VGA_WR_CLEAR_EN
  localparam int CNT_W = $clog2(BUF_WORDS + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clr_go;
  assign clr_go = bus.clr_start;
`else
  logic unused_clr;
  assign unused_clr = ^{bus.clr_start, bus.clr_buf, bus.clr_color};
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    lane_d  = lane_q;
    pix_d   = pix_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ready   = 1'b0;
`ifdef VGA_WR_CLEAR_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        ready = 1'b1;
`ifdef VGA_WR_CLEAR_EN
        // A clear command pre-empts any pixel request offered in the same cycle.
        ready = ~clr_go;
        if (clr_go) begin
          state_d = CLR;
          word_d  = bus.clr_buf ? BUF2_START : BUF1_START;
          pix_d   = bus.clr_color;
          addr_d  = word_d;
          din_d   = {bus.clr_color, bus.clr_color};
          we_d    = 1'b1;
          done_d  = (BUF_WORDS == 1);
          cnt_d   = CNT_W'(1);
        end else
`endif
        if (bus.req_valid) begin
          if (bus.req_x >= 10'd640) begin
            err_d = 1'b1;
          end else begin
            state_d = RD;
            word_d  = req_word;
            lane_d  = req_lin[0];
            pix_d   = bus.req_pixel;
            addr_d  = req_word;
          end
        end
      end
      RD:  state_d = MRG;
      MRG: begin
        // DOUT_B now holds the word addressed during RD; even x owns the high byte.
        state_d = WR;
        we_d    = 1'b1;
        addr_d  = word_q;
        din_d   = lane_q ? {bus.DOUT_B[15:8], pix_q} : {pix_q, bus.DOUT_B[7:0]};
        done_d  = 1'b1;
      end
      WR:  state_d = IDLE;
`ifdef VGA_WR_CLEAR_EN
      CLR: begin
        if (cnt_q == CNT_W'(BUF_WORDS)) begin
          state_d = IDLE;
        end else begin
          addr_d = word_q + 16'(cnt_q);
          din_d  = {pix_q, pix_q};
          we_d   = 1'b1;
          done_d = (cnt_q == CNT_W'(BUF_WORDS - 1));
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK33MHz or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      word_q  <= '0;
      lane_q  <= 1'b0;
      pix_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef VGA_WR_CLEAR_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef VGA_WR_CLEAR_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.req_ready = ready;
  assign bus.ADDR_B    = addr_q;
  assign bus.DIN_B     = din_q;
  assign bus.WE_B      = we_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_vga_buf_writer.sv
// Directed bench for vga_buf_writer with a behavioural 1-cycle-latency video RAM.
module tb_vga_buf_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  vga_buf_writer_if bus();

  vga_buf_writer dut (.CLK33MHz(clk), .RST(rst), .bus(bus));

  always #15 clk = ~clk;

  logic [15:0] mem [0:16383];
  always @(posedge clk) begin
    if (bus.WE_B) mem[bus.ADDR_B[13:0]] <= bus.DIN_B;
    bus.DOUT_B <= mem[bus.ADDR_B[13:0]];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  int          cyc = 0;
  int          wr_cnt = 0;
  int          acc_cyc = -1;
  logic        clr_mon = 1'b0;
  logic        clr_fin = 1'b0;
  int          clr_cnt = 0;
  int          bad = 0;
  logic [15:0] exp_addr = 16'd5120;
  logic [15:0] done_addr = 16'h0;
  logic        done_we = 1'b0;
  int          done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.WE_B) wr_cnt <= wr_cnt + 1;
    if (bus.req_valid && bus.req_ready) acc_cyc <= cyc;
    if (clr_mon && !clr_fin) begin
      if (bus.WE_B) begin
        clr_cnt  <= clr_cnt + 1;
        if (bus.ADDR_B !== exp_addr || bus.DIN_B !== 16'h1C1C) bad <= bad + 1;
        exp_addr <= exp_addr + 16'd1;
      end
      if (bus.done) begin
        done_addr <= bus.ADDR_B;
        done_we   <= bus.WE_B;
        done_cyc  <= cyc;
        clr_fin   <= 1'b1;
      end
    end
  end

  task automatic drv();
    @(posedge clk); #5;
  endtask

  task automatic pix_wr(input logic [9:0] x, input logic [4:0] y, input logic [7:0] p,
                        input logic [15:0] ea, input logic [15:0] ed);
    drv();
    bus.req_x = x; bus.req_y = y; bus.req_pixel = p; bus.req_valid = 1'b1;
    @(negedge clk); chk("rdy_idle", bus.req_ready, 1'b1);
    drv(); bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rd_busy", bus.busy, 1'b1); chk("rd_we", bus.WE_B, 1'b0);
    chk("rd_addr", bus.ADDR_B, ea);  chk("rd_rdy", bus.req_ready, 1'b0);
    @(negedge clk); chk("mrg_we", bus.WE_B, 1'b0);
    @(negedge clk);
    chk("wr_we", bus.WE_B, 1'b1); chk("wr_addr", bus.ADDR_B, ea);
    chk("wr_din", bus.DIN_B, ed); chk("wr_done", bus.done, 1'b1);
    @(negedge clk);
    chk("end_rdy", bus.req_ready, 1'b1); chk("end_busy", bus.busy, 1'b0);
    chk("end_done", bus.done, 1'b0);     chk("ram_word", mem[ea[13:0]], ed);
  endtask

  int w0;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0;
    bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0; bus.req_pixel = '0;
    bus.clr_start = 1'b0; bus.clr_buf = 1'b0; bus.clr_color = '0;

    @(negedge clk);
    chk("rst_we", bus.WE_B, 1'b0);     chk("rst_addr", bus.ADDR_B, 16'h0);
    chk("rst_din", bus.DIN_B, 16'h0);  chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);     chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rdy", bus.req_ready, 1'b1);
    drv(); rst = 1'b0;

    mem[1] = 16'h1234;
    pix_wr(10'd3, 5'd0, 8'hAB, 16'd1, 16'h12AB);
    mem[1] = 16'h1234;
    pix_wr(10'd2, 5'd0, 8'hAB, 16'd1, 16'hAB34);
    mem[5440] = 16'h9876;
    pix_wr(10'd0, 5'd17, 8'h55, 16'd5440, 16'h5576);
    mem[10239] = 16'hC3C3;
    pix_wr(10'd639, 5'd31, 8'h0F, 16'd10239, 16'hC30F);

    // Out-of-range column: error pulse only.
    w0 = wr_cnt;
    drv(); bus.req_x = 10'd640; bus.req_y = 5'd0; bus.req_valid = 1'b1;
    drv(); bus.req_valid = 1'b0;
    @(negedge clk);
    chk("err_pulse", bus.err, 1'b1); chk("err_busy", bus.busy, 1'b0);
    chk("err_rdy", bus.req_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("err_clr", bus.err, 1'b0); chk("err_nowr", wr_cnt - w0, 0);

    // Clear and pixel request offered together.
    mem[5119] = 16'h4242; mem[10240] = 16'hBEEF; mem[5120] = 16'hA5A5; mem[2] = 16'h0000;
    w0 = wr_cnt;
    drv();
    bus.clr_buf = 1'b1; bus.clr_color = 8'h1C; bus.clr_start = 1'b1;
    bus.req_x = 10'd5; bus.req_y = 5'd0; bus.req_pixel = 8'h77; bus.req_valid = 1'b1;
`ifdef VGA_WR_CLEAR_EN
    clr_mon = 1'b1;
    @(negedge clk); chk("clr_rdy", bus.req_ready, 1'b0);
`else
    @(negedge clk); chk("clr_rdy", bus.req_ready, 1'b1);
`endif
    drv(); bus.clr_start = 1'b0;
    for (int i = 0; i < 6000 && acc_cyc < 0; i++) @(negedge clk);
    chk("acc_seen", acc_cyc >= 0, 1'b1);
    drv(); bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("clr_pix", mem[2], 16'h0077);
    chk("clr_pre", mem[5119], 16'h4242);
    chk("clr_post", mem[10240], 16'hBEEF);
`ifdef VGA_WR_CLEAR_EN
    chk("clr_cnt", clr_cnt, 5120);       chk("clr_bad", bad, 0);
    chk("clr_done_a", done_addr, 16'd10239); chk("clr_done_we", done_we, 1'b1);
    chk("clr_acc", acc_cyc > done_cyc, 1'b1);
    chk("clr_first", mem[5120], 16'h1C1C); chk("clr_last", mem[10239], 16'h1C1C);
    chk("clr_wrs", wr_cnt - w0, 5121);

    // Reset during the 100th write of a buffer-1 clear.
    mem[98] = 16'h1111; mem[100] = 16'h7777; mem[150] = 16'hCAFE;
    drv(); bus.clr_buf = 1'b0; bus.clr_color = 8'h33; bus.clr_start = 1'b1;
    drv(); bus.clr_start = 1'b0;
    repeat (99) @(posedge clk);
    #5;
    chk("cr_we", bus.WE_B, 1'b1); chk("cr_addr", bus.ADDR_B, 16'd99);
    rst = 1'b1; #1;
    chk("cr_we_rst", bus.WE_B, 1'b0); chk("cr_busy", bus.busy, 1'b0);
    drv(); rst = 1'b0;
    @(negedge clk);
    chk("cr_rdy", bus.req_ready, 1'b1); chk("cr_busy2", bus.busy, 1'b0);
    chk("cr_m98", mem[98], 16'h3333); chk("cr_m100", mem[100], 16'h7777);
    chk("cr_m150", mem[150], 16'hCAFE);
`else
    chk("clr_none", mem[5120], 16'hA5A5);
    chk("clr_wrs", wr_cnt - w0, 1);
`endif

    // Reset during a pixel write strobe: strobe drops at once, word untouched.
    mem[3] = 16'h5555;
    drv(); bus.req_x = 10'd7; bus.req_y = 5'd0; bus.req_pixel = 8'hEE; bus.req_valid = 1'b1;
    drv(); bus.req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #5;
    chk("pr_we", bus.WE_B, 1'b1); chk("pr_din", bus.DIN_B, 16'h55EE);
    rst = 1'b1; #1;
    chk("pr_we_rst", bus.WE_B, 1'b0); chk("pr_addr_rst", bus.ADDR_B, 16'h0);
    drv(); rst = 1'b0;
    @(negedge clk);
    chk("pr_rdy", bus.req_ready, 1'b1); chk("pr_mem", mem[3], 16'h5555);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
